// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: request struct,
// grant-source encoding and widths.
package rf_write_arbiter_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  wa;
    logic [DATA_W-1:0] wd;
  } wr_req_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_BUF} gnt_src_e;

  // r0 is hardwired zero, so a write aimed at it is a no-op
  function automatic logic is_live(input logic [REG_W-1:0] wa);
    return wa != '0;
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback, long-latency, decode-hazard and register-file signals
// around the write-port arbiter.
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic              wb_we;
  logic [REG_W-1:0]  wb_wa;
  logic [DATA_W-1:0] wb_wd;
  logic              wb_hold;
  logic              sec_valid;
  logic [REG_W-1:0]  sec_wa;
  logic [DATA_W-1:0] sec_wd;
  logic              sec_ready;
  logic              iss_valid;
  logic [REG_W-1:0]  iss_wa;
  logic [REG_W-1:0]  dec_ra1;
  logic [REG_W-1:0]  dec_ra2;
  logic              dec_we;
  logic [REG_W-1:0]  dec_wa;
  logic              dec_stall;
  logic              rf_we;
  logic [REG_W-1:0]  rf_wa;
  logic [DATA_W-1:0] rf_wd;

  modport master (
    output wb_we, wb_wa, wb_wd, sec_valid, sec_wa, sec_wd,
           iss_valid, iss_wa, dec_ra1, dec_ra2, dec_we, dec_wa,
    input  wb_hold, sec_ready, dec_stall, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  wb_we, wb_wa, wb_wd, sec_valid, sec_wa, sec_wd,
           iss_valid, iss_wa, dec_ra1, dec_ra2, dec_we, dec_wa,
    output wb_hold, sec_ready, dec_stall, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_wr_fifo.sv
// Completion buffer for long-latency results; head is visible combinationally,
// so an entry becomes grantable the cycle after it is pushed.
module rf_wr_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t din,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  wr_req_t       mem [DEPTH];
  logic [AW:0]   wp, rp;
  logic          push_ok, pop_ok;

  // extra pointer MSB distinguishes full from empty
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head    = mem[rp[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by writeback and a long-latency unit,
// with starvation protection and a pending-write scoreboard for decode hazards.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  rf_write_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wr_req_t     head, push_req;
  logic        full, empty, push, pop, ready;
  logic        wb_req, starve_hit;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] pend_q, pend_d;
  gnt_src_e    gnt;

  assign wb_req     = bus.wb_we && is_live(bus.wb_wa);
  assign starve_hit = !empty && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    gnt = GNT_NONE;
    if (!rst_n)          gnt = GNT_NONE;
    else if (starve_hit) gnt = GNT_BUF;
    else if (wb_req)     gnt = GNT_WB;
    else if (!empty)     gnt = GNT_BUF;
  end

  assign pop      = (gnt == GNT_BUF);
  assign ready    = rst_n && !full;
  assign push     = bus.sec_valid && ready && is_live(bus.sec_wa);
  assign push_req = '{we: 1'b1, wa: bus.sec_wa, wd: bus.sec_wd};

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_req),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Register file writes on the falling edge, so the port is driven combinationally
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    case (gnt)
      GNT_WB: begin
        bus.rf_we = 1'b1;
        bus.rf_wa = bus.wb_wa;
        bus.rf_wd = bus.wb_wd;
      end
      GNT_BUF: begin
        bus.rf_we = head.we;
        bus.rf_wa = head.wa;
        bus.rf_wd = head.wd;
      end
      default: ;
    endcase
  end

  assign bus.wb_hold   = (gnt == GNT_BUF) && wb_req;
  assign bus.sec_ready = ready;

  always_comb begin
    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (gnt == GNT_WB && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  // Clear first so a same-cycle re-issue to the drained register stays pending
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head.wa] = 1'b0;
    if (bus.iss_valid) pend_d[bus.iss_wa] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.dec_stall = rst_n && (pend_q[bus.dec_ra1] || pend_q[bus.dec_ra2] ||
                                   (bus.dec_we && pend_q[bus.dec_wa]) ||
                                   (bus.iss_valid && pend_q[bus.iss_wa]));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for the write-port arbiter, checked every
// cycle against a queue-based reference model.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // reference model state
  wr_req_t     mq[$];
  bit [31:0]   mpend;
  int          mstarve;
  int          ll_q[$];

  int vecs = 0;
  int errs = 0;

  logic        s_we, s_hold, s_ready, s_stall, s_xfer;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
    bus.sec_valid = 0; bus.sec_wa = 0; bus.sec_wd = 0;
    bus.iss_valid = 0; bus.iss_wa = 0;
    bus.dec_ra1 = 0; bus.dec_ra2 = 0; bus.dec_we = 0; bus.dec_wa = 0;
  endtask

  // one clock: check outputs at negedge, advance model after posedge
  task automatic step();
    bit wbreq, ne, gbuf, gwb, e_ready, e_stall;
    @(negedge clk);
    s_we = bus.rf_we; s_wa = bus.rf_wa; s_wd = bus.rf_wd;
    s_hold = bus.wb_hold; s_ready = bus.sec_ready; s_stall = bus.dec_stall;
    if (!rst_n) begin
      chk("rst_rf_we", s_we, 0);
      chk("rst_hold", s_hold, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_stall", s_stall, 0);
      mq.delete(); mpend = '0; mstarve = 0; ll_q.delete(); s_xfer = 0;
      @(posedge clk); #1;
      return;
    end
    wbreq   = bus.wb_we && bus.wb_wa != 0;
    ne      = mq.size() != 0;
    e_ready = mq.size() < DEPTH;
    gbuf    = ne && (mstarve == LIM || !wbreq);
    gwb     = !gbuf && wbreq;
    e_stall = mpend[bus.dec_ra1] || mpend[bus.dec_ra2] ||
              (bus.dec_we && mpend[bus.dec_wa]) || (bus.iss_valid && mpend[bus.iss_wa]);
    chk("rf_we", s_we, gbuf || gwb);
    if (gbuf) begin
      chk("rf_wa_buf", s_wa, mq[0].wa);
      chk("rf_wd_buf", s_wd, mq[0].wd);
    end else if (gwb) begin
      chk("rf_wa_wb", s_wa, bus.wb_wa);
      chk("rf_wd_wb", s_wd, bus.wb_wd);
    end
    chk("wb_hold", s_hold, gbuf && wbreq);
    chk("sec_ready", s_ready, e_ready);
    chk("dec_stall", s_stall, e_stall);
    s_xfer = bus.sec_valid && e_ready;
    @(posedge clk);
    if (!ne || gbuf) mstarve = 0;
    else if (gwb && mstarve < LIM) mstarve++;
    if (gbuf) begin
      mpend[mq[0].wa] = 1'b0;
      void'(mq.pop_front());
    end
    if (s_xfer && bus.sec_wa != 0) mq.push_back('{we: 1'b1, wa: bus.sec_wa, wd: bus.sec_wd});
    if (bus.iss_valid && bus.iss_wa != 0) mpend[bus.iss_wa] = 1'b1;
    #1;
  endtask

  // long-latency protocol watch
  logic pv = 1'b0, px = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.sec_valid && bus.sec_wa != 0)
      assert (mpend[bus.sec_wa]) else $error("protocol: sec_wa %0d not pending", bus.sec_wa);
    if (rst_n && pv && !px)
      assert (bus.sec_valid) else $error("protocol: sec_valid dropped before transfer");
    pv <= rst_n && bus.sec_valid;
    px <= bus.sec_valid && bus.sec_ready;
  end

  initial begin
    int ord[$];
    bit stall_pre;
    clr();
    mq.delete(); mpend = '0; mstarve = 0;
    step();
    rst_n = 1'b1;

    // writeback on idle buffer goes straight through
    bus.wb_we = 1; bus.wb_wa = 8; bus.wb_wd = 32'hDEADBEEF;
    step();
    chk("t1_we", s_we, 1); chk("t1_wa", s_wa, 8);
    chk("t1_wd", s_wd, 32'hDEADBEEF); chk("t1_hold", s_hold, 0);

    // RAW stall until long-latency result drains
    clr(); bus.iss_valid = 1; bus.iss_wa = 5;
    step();
    clr(); bus.dec_ra1 = 5;
    step();
    chk("t2_stall_a", s_stall, 1);
    bus.sec_valid = 1; bus.sec_wa = 5; bus.sec_wd = 32'h1234;
    step();
    chk("t2_stall_b", s_stall, 1); chk("t2_no_bypass", s_we, 0);
    clr(); bus.dec_ra1 = 5;
    step();
    chk("t2_we", s_we, 1); chk("t2_wa", s_wa, 5); chk("t2_wd", s_wd, 32'h1234);
    step();
    chk("t2_stall_c", s_stall, 0);

    // starvation: writeback wins LIM times, then buffer forces a hold
    clr(); bus.iss_valid = 1; bus.iss_wa = 9;
    step();
    clr(); bus.sec_valid = 1; bus.sec_wa = 9; bus.sec_wd = 32'hAAAA;
    step();
    clr(); bus.wb_we = 1; bus.wb_wa = 10; bus.wb_wd = 32'h10;
    for (int i = 0; i < LIM; i++) begin
      step();
      chk("t3_wb_wa", s_wa, 10); chk("t3_wb_hold", s_hold, 0);
    end
    step();
    chk("t3_force_wa", s_wa, 9); chk("t3_force_hold", s_hold, 1);
    step();
    chk("t3_held_wa", s_wa, 10); chk("t3_held_hold", s_hold, 0);

    // fill buffer under writeback pressure; held sec result must survive
    clr();
    bus.iss_valid = 1; bus.iss_wa = 3; step();
    bus.iss_wa = 4; step();
    bus.iss_wa = 6; step();
    clr(); bus.wb_we = 1; bus.wb_wa = 11; bus.wb_wd = 32'h11;
    ord.delete();
    bus.sec_valid = 1; bus.sec_wa = 3; bus.sec_wd = 32'h3; step();
    bus.sec_wa = 4; bus.sec_wd = 32'h4; step();
    if (s_we && s_wa != 11) ord.push_back(s_wa);
    bus.sec_wa = 6; bus.sec_wd = 32'h6; step();
    chk("t4_full", s_ready, 0);
    if (s_we && s_wa != 11) ord.push_back(s_wa);
    for (int k = 0; k < 20 && !s_xfer; k++) begin
      step();
      if (s_we && s_wa != 11) ord.push_back(s_wa);
    end
    chk("t4_xfer", s_xfer, 1);
    bus.sec_valid = 0; bus.wb_we = 0;
    repeat (4) begin
      step();
      if (s_we && s_wa != 11) ord.push_back(s_wa);
    end
    chk("t4_count", ord.size(), 3);
    if (ord.size() == 3) begin
      chk("t4_ord0", ord[0], 3); chk("t4_ord1", ord[1], 4); chk("t4_ord2", ord[2], 6);
    end

    // r0 writeback never consumes the port; r0 sec result is dropped
    clr(); bus.iss_valid = 1; bus.iss_wa = 12; step();
    clr(); bus.sec_valid = 1; bus.sec_wa = 12; bus.sec_wd = 32'hC; step();
    clr(); bus.wb_we = 1; bus.wb_wa = 0; bus.wb_wd = 32'h5555; step();
    chk("t5_we", s_we, 1); chk("t5_wa", s_wa, 12); chk("t5_hold", s_hold, 0);
    clr(); bus.sec_valid = 1; bus.sec_wa = 0; bus.sec_wd = 32'hFFFF; step();
    chk("t5_r0_a", s_we, 0);
    clr(); step();
    chk("t5_r0_b", s_we, 0);

    // reset mid-drain discards buffer and scoreboard
    clr(); bus.iss_valid = 1; bus.iss_wa = 5; step();
    bus.iss_wa = 7; step();
    clr(); bus.wb_we = 1; bus.wb_wa = 13; bus.wb_wd = 32'h13;
    bus.sec_valid = 1; bus.sec_wa = 5; bus.sec_wd = 32'h55; step();
    bus.sec_wa = 7; bus.sec_wd = 32'h77; step();
    bus.sec_valid = 0; bus.dec_ra1 = 5;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clr(); bus.dec_ra1 = 5;
    step();
    chk("t6_stall", s_stall, 0); chk("t6_we", s_we, 0);

    // randomized traffic against the model
    clr();
    for (int c = 0; c < 3000; c++) begin
      if (!s_hold) begin
        bus.wb_we = ($urandom % 3) != 0;
        bus.wb_wa = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
        bus.wb_wd = $urandom;
      end
      if (s_xfer) bus.sec_valid = 0;
      if (!bus.sec_valid && ll_q.size() != 0 && ($urandom % 2) != 0) begin
        bus.sec_valid = 1;
        bus.sec_wa = 5'(ll_q.pop_front());
        bus.sec_wd = $urandom;
      end
      bus.dec_ra1 = 5'($urandom); bus.dec_ra2 = 5'($urandom);
      bus.dec_we = 1'($urandom); bus.dec_wa = 5'($urandom);
      bus.iss_wa = 5'(1 + $urandom % 31);
      stall_pre = mpend[bus.dec_ra1] || mpend[bus.dec_ra2] || (bus.dec_we && mpend[bus.dec_wa]);
      bus.iss_valid = ($urandom % 3 == 0) && !stall_pre && !mpend[bus.iss_wa];
      if (bus.iss_valid) ll_q.push_back(int'(bus.iss_wa));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
